adc128s: RTL and testbench

//  Synthesizable behavioural model of an ADC128S 8-channel, 12-bit A2D converter with an SPI slave port.

---
 rtl/a2d_pkg.sv | 15 +
 rtl/spi_edge_sync.sv | 33 +++
 rtl/adc128s.sv | 104 ++++++++++
 tb/tb_adc128s.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared A2D definitions: channel map and sample type.
// Used by the ADC model and the Segway A2D interface.
package a2d_pkg;

  typedef logic [11:0] a2d_data_t;

  localparam logic [2:0] LFT_CH  = 3'd0;
  localparam logic [2:0] RGHT_CH = 3'd4;
  localparam logic [2:0] BATT_CH = 3'd5;

  localparam a2d_data_t UNUSED_D = 12'h000;

  localparam logic [4:0] WORD_BITS = 5'd16;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer plus a third flop for edge detect.
// Edges are derived from synced values only.
module spi_edge_sync #(
  parameter logic PRESET = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic ff1, ff2, ff3;

  // Sync chain; presets to the idle level of the line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff1 <= PRESET;
      ff2 <= PRESET;
      ff3 <= PRESET;
    end else begin
      ff1 <= din;
      ff2 <= ff1;
      ff3 <= ff2;
    end
  end

  assign sync = ff2;
  assign rise = ff2 & ~ff3;
  assign fall = ~ff2 & ff3;

endmodule

// File: rtl/adc128s.sv
// ADC128S behavioural model with SPI slave port.
// Channel sent in word N is answered in word N+1.
module adc128s
  import a2d_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      SS_n,
  input  logic      SCLK,
  input  logic      MOSI,
  output logic      MISO,
  input  a2d_data_t batt_set,
  input  a2d_data_t lft_cell_set,
  input  a2d_data_t rght_cell_set
);

  logic ss_sync, ss_rise, ss_fall;
  logic sclk_sync, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise, mosi_fall;

  logic [2:0]  chnl_ptr;
  a2d_data_t   result;
  logic [15:0] tx_shft;
  logic [15:0] rx_shft;
  logic [4:0]  bit_cnt;
  logic [2:0]  cmd_ch;
  a2d_data_t   ch_val;

  spi_edge_sync #(.PRESET(1'b1)) u_ss (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (SS_n),
    .sync (ss_sync),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  spi_edge_sync #(.PRESET(1'b1)) u_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (SCLK),
    .sync (sclk_sync),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_edge_sync #(.PRESET(1'b1)) u_mosi (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (MOSI),
    .sync (mosi_sync),
    .rise (mosi_rise),
    .fall (mosi_fall)
  );

  assign cmd_ch = rx_shft[13:11];

  // Channel mux: pick the set value for the commanded channel.
  always_comb begin
    ch_val = UNUSED_D;
    unique case (1'b1)
      (cmd_ch == LFT_CH):  ch_val = lft_cell_set;
      (cmd_ch == RGHT_CH): ch_val = rght_cell_set;
      (cmd_ch == BATT_CH): ch_val = batt_set;
      default:             ch_val = UNUSED_D;
    endcase
  end

  // Shift engine; SS_n fall outranks a same-cycle SCLK edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chnl_ptr <= 3'd0;
      result   <= 12'h000;
      tx_shft  <= 16'h0000;
      rx_shft  <= 16'h0000;
      bit_cnt  <= 5'd0;
    end else begin
      if (ss_fall) begin
        tx_shft <= {4'h0, result};
        bit_cnt <= 5'd0;
      end else if (!ss_sync) begin
        if (sclk_rise) begin
          rx_shft <= {rx_shft[14:0], mosi_sync};
          if (bit_cnt != WORD_BITS)
            bit_cnt <= bit_cnt + 5'd1;
        end
        if (sclk_fall && bit_cnt != 5'd0)
          tx_shft <= {tx_shft[14:0], 1'b0};
      end
      if (ss_rise && bit_cnt == WORD_BITS) begin
        chnl_ptr <= cmd_ch;
        result   <= ch_val;
      end
    end
  end

  assign MISO = ss_sync ? 1'b1 : tx_shft[15];

  logic unused_ok;
  assign unused_ok = ^{rx_shft[15:14], rx_shft[10:0],
                       mosi_rise, mosi_fall,
                       sclk_sync, chnl_ptr};

endmodule

// File: tb/tb_adc128s.sv
// Self-checking bench for adc128s.
// Table vectors, corner sequences, random pipelined reads.
module tb_adc128s;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [11:0] batt_set = 12'h000;
  logic [11:0] lft_cell_set = 12'h000;
  logic [11:0] rght_cell_set = 12'h000;

  int n_vec = 0;
  int n_bad = 0;

  adc128s dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .SS_n         (SS_n),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .batt_set     (batt_set),
    .lft_cell_set (lft_cell_set),
    .rght_cell_set(rght_cell_set)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cmd;
    logic [11:0] lft;
    logic [11:0] rght;
    logic [11:0] batt;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[6];

  // Reference: last fully received command decides the next reply.
  logic [15:0] model_next;

  function automatic logic [15:0] model_reply(input logic [15:0] cmd);
    logic [2:0] ch;
    ch = cmd[13:11];
    if (ch == 3'd0) return {4'h0, lft_cell_set};
    if (ch == 3'd4) return {4'h0, rght_cell_set};
    if (ch == 3'd5) return {4'h0, batt_set};
    return 16'h0000;
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 master: MOSI set before rise, MISO sampled at rise.
  task automatic xfer(input logic [15:0] cmd, input int nbits,
                      input bit glitch, input bit chg,
                      output logic [15:0] resp);
    resp = 16'h0000;
    @(negedge clk);
    SS_n = 1'b0;
    if (glitch) SCLK = 1'b1;
    tick(8);
    if (glitch) begin
      SCLK = 1'b0;
      tick(8);
    end
    for (int i = 0; i < nbits; i++) begin
      MOSI = (i < 16) ? cmd[15-i] : 1'b0;
      tick(8);
      SCLK = 1'b1;
      if (i < 16) resp[15-i] = MISO;
      if (chg && i == 8) begin
        lft_cell_set  = 12'($urandom);
        rght_cell_set = 12'($urandom);
        batt_set      = 12'($urandom);
      end
      tick(8);
      SCLK = 1'b0;
    end
    tick(8);
    SS_n = 1'b1;
    tick(8);
  endtask

  logic [15:0] r;
  logic [15:0] c;
  logic [2:0]  ch;

  initial begin
    tbl[0] = '{16'h0000, 12'h130, 12'h000, 12'h000, 16'h0000};
    tbl[1] = '{16'h2000, 12'h130, 12'h190, 12'h000, 16'h0130};
    tbl[2] = '{16'h2000, 12'h130, 12'h200, 12'h000, 16'h0190};
    tbl[3] = '{16'h2800, 12'h130, 12'h200, 12'hA5B, 16'h0200};
    tbl[4] = '{16'h1000, 12'h130, 12'h200, 12'hA5B, 16'h0A5B};
    tbl[5] = '{16'h2000, 12'h130, 12'h200, 12'hA5B, 16'h0000};

    tick(4);
    check("reset_miso", {15'h0, MISO}, 16'h0001);
    rst_n = 1'b1;
    tick(4);
    check("idle_miso", {15'h0, MISO}, 16'h0001);

    for (int i = 0; i < 6; i++) begin
      lft_cell_set  = tbl[i].lft;
      rght_cell_set = tbl[i].rght;
      batt_set      = tbl[i].batt;
      xfer(tbl[i].cmd, 16, 1'b0, 1'b0, r);
      check($sformatf("tbl%0d", i), r, tbl[i].exp);
    end
    check("miso_after_word", {15'h0, MISO}, 16'h0001);

    // Aborted ch5 command must not disturb the held ch4 sample.
    rght_cell_set = 12'h333;
    batt_set      = 12'h777;
    xfer(16'h2800, 8, 1'b0, 1'b0, r);
    xfer(16'h0000, 16, 1'b0, 1'b0, r);
    check("abort_keeps", r, 16'h0200);

    // SS_n fall with SCLK rise in the same clk: rise ignored.
    lft_cell_set = 12'h5C3;
    xfer(16'h2800, 16, 1'b1, 1'b0, r);
    check("glitch_resp", r, 16'h0130);
    xfer(16'h0000, 16, 1'b0, 1'b0, r);
    check("glitch_cmd", r, 16'h0777);

    // Pipelined random reads with set values changing mid-word.
    model_next = {4'h0, lft_cell_set};
    for (int i = 0; i < 30; i++) begin
      c = 16'($urandom);
      case ($urandom_range(0, 3))
        0: ch = 3'd0;
        1: ch = 3'd4;
        2: ch = 3'd5;
        default: ch = 3'($urandom);
      endcase
      c[13:11] = ch;
      xfer(c, 16, 1'b0, (i % 3) == 1, r);
      check($sformatf("rand%0d", i), r, model_next);
      model_next = model_reply(c);
    end

    // Reset mid-word: MISO idles high, next word is a first word.
    lft_cell_set = 12'hFFF;
    @(negedge clk);
    SS_n = 1'b0;
    tick(8);
    for (int i = 0; i < 5; i++) begin
      MOSI = 1'b1;
      tick(8);
      SCLK = 1'b1;
      tick(8);
      SCLK = 1'b0;
    end
    rst_n = 1'b0;
    tick(2);
    check("rst_mid_miso", {15'h0, MISO}, 16'h0001);
    SS_n = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(8);
    check("rst_idle_miso", {15'h0, MISO}, 16'h0001);
    xfer(16'h0000, 16, 1'b0, 1'b0, r);
    check("rst_first", r, 16'h0000);
    xfer(16'h0000, 16, 1'b0, 1'b0, r);
    check("rst_second", r, 16'h0FFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
